sha1_core_gen: RTL and testbench

Parameterised SHA-1 compression engine, next generation of the HMAC-SHA1 hash cores. It processes one pre-padded 512-bit block per transaction and unrolls 1, 2, 4 or 5 rounds per cycle. The 80-word schedule store is replaced by a 16-word rolling window. Chaining can start from the standard IV, from the previous digest, or from an externally supplied 160-bit midstate, so HMAC inner and outer passes can reuse precomputed ipad/opad states. It sits between the HMAC controller (block producer) and the digest consumer.

---
 rtl/sha1_core_gen.sv | 235 +++++++++++++++++++++++
 tb/tb_sha1_core_gen.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha1_core_gen.sv
// sha1_core_gen -- SHA-1 compression engine, one pre-padded 512-bit block per
// transaction, RPC rounds unrolled per clock (RPC in {1,2,4,5}).
//
// Ports
//   clk, rst_n      clock (rising edge), synchronous active-low reset
//   blk_valid/ready block handshake; blk_ready is high only in IDLE
//   blk_data        512-bit padded block, W0 in [511:480]
//   blk_first       1 = start a new chain, 0 = continue from H
//   iv_use          with blk_first=1: 1 = chain from iv_in, 0 = standard IV
//   iv_in           160-bit midstate {A,B,C,D,E}
//   abort           cancel the block in flight (also blocks an accept in IDLE)
//   out_valid       one-cycle pulse when hash_out is refreshed
//   hash_out        {H0..H4}, held until the next completed block
//   busy            high in RUN and FINAL
//
// Handshake: a block is accepted on a rising edge where blk_valid=1,
// blk_ready=1 and abort=0. The producer holds blk_valid and its data stable
// until that edge; blk_valid while blk_ready=0 has no effect. blk_first,
// iv_use and iv_in are sampled only at the accept edge.
//
// FSM state lives in state_q (enum state_t) so checkers can bind to it.

`default_nettype none

module sha1_core_gen #(
    parameter int RPC = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         blk_valid,
    output logic         blk_ready,
    input  logic [511:0] blk_data,
    input  logic         blk_first,
    input  logic         iv_use,
    input  logic [159:0] iv_in,
    input  logic         abort,
    output logic         out_valid,
    output logic [159:0] hash_out,
    output logic         busy
);

    // Unroll factor must divide 20 so a cycle never straddles a K boundary.
    generate
        if (!(RPC == 1 || RPC == 2 || RPC == 4 || RPC == 5)) begin : g_bad_rpc
            $error("sha1_core_gen: RPC must be 1, 2, 4 or 5");
        end
    endgenerate

    localparam logic [159:0] STD_IV =
        160'h67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0;
    localparam logic [6:0] T_STEP = 7'(RPC);
    localparam logic [6:0] T_LAST = 7'(80 - RPC);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FINAL = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [6:0]     t_q, t_d;             // index of the first round of this cycle
    logic [511:0]   w_q, w_d;             // rolling window W[t..t+15], W[t] in [511:480]
    logic [159:0]   work_q, work_d;       // working variables {a,b,c,d,e}
    logic [159:0]   h_q, h_d;             // chaining value for the block in flight
    logic [159:0]   h_save_q, h_save_d;   // chaining value before the last accept
    logic [159:0]   hash_q, hash_d;
    logic           out_valid_q, out_valid_d;
    logic [1:0]     grp;
    logic [159:0]   start_val;
    logic [159:0]   h_sum;

    function automatic logic [31:0] rotl1(input logic [31:0] x);
        return {x[30:0], x[31]};
    endfunction

    function automatic logic [31:0] rotl5(input logic [31:0] x);
        return {x[26:0], x[31:27]};
    endfunction

    function automatic logic [31:0] rotl30(input logic [31:0] x);
        return {x[1:0], x[31:2]};
    endfunction

    // Advance the window by RPC words. Newly generated words are appended to
    // the extended array, so words made earlier in the cycle feed later ones.
    function automatic logic [511:0] next_window(input logic [511:0] win);
        logic [31:0]  ext [0:15+RPC];
        logic [511:0] res;
        for (int i = 0; i < 16; i++) begin
            ext[i] = win[511-32*i -: 32];
        end
        for (int j = 0; j < RPC; j++) begin
            ext[16+j] = rotl1(ext[13+j] ^ ext[8+j] ^ ext[2+j] ^ ext[j]);
        end
        res = '0;
        for (int i = 0; i < 16; i++) begin
            res[511-32*i -: 32] = ext[RPC+i];
        end
        return res;
    endfunction

    // RPC chained rounds; all rounds of one cycle share the same f/K group.
    function automatic logic [159:0] do_rounds(input logic [159:0] s,
                                               input logic [511:0] win,
                                               input logic [1:0]   g);
        logic [31:0] a, b, c, d, e, f, k, w, tmp;
        a = s[159:128];
        b = s[127:96];
        c = s[95:64];
        d = s[63:32];
        e = s[31:0];
        for (int r = 0; r < RPC; r++) begin
            w = win[511-32*r -: 32];
            case (g)
                2'd0:    begin f = (b & c) | (~b & d);          k = 32'h5A827999; end
                2'd1:    begin f = b ^ c ^ d;                   k = 32'h6ED9EBA1; end
                2'd2:    begin f = (b & c) | (b & d) | (c & d); k = 32'h8F1BBCDC; end
                default: begin f = b ^ c ^ d;                   k = 32'hCA62C1D6; end
            endcase
            tmp = rotl5(a) + f + e + k + w;
            e = d;
            d = c;
            c = rotl30(b);
            b = a;
            a = tmp;
        end
        return {a, b, c, d, e};
    endfunction

    function automatic logic [159:0] add_state(input logic [159:0] x,
                                               input logic [159:0] y);
        logic [159:0] res;
        for (int i = 0; i < 5; i++) begin
            res[159-32*i -: 32] = x[159-32*i -: 32] + y[159-32*i -: 32];
        end
        return res;
    endfunction

    always_comb begin
        if (t_q < 7'd20)      grp = 2'd0;
        else if (t_q < 7'd40) grp = 2'd1;
        else if (t_q < 7'd60) grp = 2'd2;
        else                  grp = 2'd3;
    end

    always_comb begin
        if (!blk_first)  start_val = h_q;
        else if (iv_use) start_val = iv_in;
        else             start_val = STD_IV;
    end

    assign h_sum = add_state(h_q, work_q);

    always_comb begin
        state_d     = state_q;
        t_d         = t_q;
        w_d         = w_q;
        work_d      = work_q;
        h_d         = h_q;
        h_save_d    = h_save_q;
        hash_d      = hash_q;
        out_valid_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (blk_valid && !abort) begin
                    h_save_d = h_q;
                    h_d      = start_val;
                    work_d   = start_val;
                    w_d      = blk_data;
                    t_d      = '0;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    // Restore the chain so a later blk_first=0 block continues it.
                    h_d     = h_save_q;
                    state_d = ST_IDLE;
                end else begin
                    work_d = do_rounds(work_q, w_q, grp);
                    w_d    = next_window(w_q);
                    t_d    = t_q + T_STEP;
                    if (t_q == T_LAST) begin
                        state_d = ST_FINAL;
                    end
                end
            end
            ST_FINAL: begin
                if (abort) begin
                    h_d     = h_save_q;
                    state_d = ST_IDLE;
                end else begin
                    h_d         = h_sum;
                    hash_d      = h_sum;
                    out_valid_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            t_q         <= '0;
            w_q         <= '0;
            work_q      <= '0;
            h_q         <= STD_IV;
            h_save_q    <= STD_IV;
            hash_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            t_q         <= t_d;
            w_q         <= w_d;
            work_q      <= work_d;
            h_q         <= h_d;
            h_save_q    <= h_save_d;
            hash_q      <= hash_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign blk_ready = (state_q == ST_IDLE);
    assign busy      = (state_q == ST_RUN) || (state_q == ST_FINAL);
    assign out_valid = out_valid_q;
    assign hash_out  = hash_q;

endmodule

`default_nettype wire

// File: tb/tb_sha1_core_gen.sv
// tb_sha1_core_gen -- directed bench for sha1_core_gen. Expected digests come
// from known-answer constants and from a straightforward 80-word SHA-1 model.

`timescale 1ns/1ps

module tb_sha1_core_gen;

    parameter int TB_RPC = 1;
    localparam int N = 80 / TB_RPC;

    localparam logic [159:0] STD_IV  = 160'h67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0;
    localparam logic [159:0] DIG_ABC = 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d;
    localparam logic [159:0] DIG_M2  = 160'h84983e44_1c3bd26e_baae4aa1_f95129e5_e54670f1;
    localparam logic [511:0] BLK_ABC = {32'h61626380, {14{32'h00000000}}, 32'h00000018};
    localparam logic [511:0] BLK_M1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] BLK_M2  = {{15{32'h00000000}}, 32'h000001c0};

    // ---------------- clock / reset ----------------
    logic         clk;
    logic         rst_n;
    logic         blk_valid;
    logic         blk_ready;
    logic [511:0] blk_data;
    logic         blk_first;
    logic         iv_use;
    logic [159:0] iv_in;
    logic         abort;
    logic         out_valid;
    logic [159:0] hash_out;
    logic         busy;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    sha1_core_gen #(.RPC(TB_RPC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_data  (blk_data),
        .blk_first (blk_first),
        .iv_use    (iv_use),
        .iv_in     (iv_in),
        .abort     (abort),
        .out_valid (out_valid),
        .hash_out  (hash_out),
        .busy      (busy)
    );

    // ---------------- scoreboard state ----------------
    logic [159:0] exp_q[$];
    int           lat_q[$];
    int           n_cmp = 0;
    int           n_fail = 0;
    int           n_pulse = 0;
    int           n_expected = 0;
    int           ov_last = 0;
    int           ov_prev = 0;
    logic         prev_ov = 1'b0;

    task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Reference SHA-1 compression with the full 80-word schedule.
    function automatic logic [159:0] ref_sha1(input logic [159:0] hin, input logic [511:0] blk);
        logic [31:0] w [0:79];
        logic [31:0] a, b, c, d, e, f, k, tmp, x;
        for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
        for (int t = 16; t < 80; t++) begin
            x = w[t-3] ^ w[t-8] ^ w[t-14] ^ w[t-16];
            w[t] = (x << 1) | (x >> 31);
        end
        a = hin[159:128]; b = hin[127:96]; c = hin[95:64]; d = hin[63:32]; e = hin[31:0];
        for (int t = 0; t < 80; t++) begin
            if (t < 20)      begin f = (b & c) | (~b & d);          k = 32'h5A827999; end
            else if (t < 40) begin f = b ^ c ^ d;                   k = 32'h6ED9EBA1; end
            else if (t < 60) begin f = (b & c) | (b & d) | (c & d); k = 32'h8F1BBCDC; end
            else             begin f = b ^ c ^ d;                   k = 32'hCA62C1D6; end
            tmp = ((a << 5) | (a >> 27)) + f + e + k + w[t];
            e = d; d = c; c = (b << 30) | (b >> 2); b = a; a = tmp;
        end
        return {hin[159:128] + a, hin[127:96] + b, hin[95:64] + c, hin[63:32] + d, hin[31:0] + e};
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            n_pulse++;
            ov_prev = ov_last;
            ov_last = cyc;
            chk("out_valid_single_cycle", {159'd0, prev_ov}, 160'd0);
            n_cmp++;
            assert (exp_q.size() != 0) else begin
                n_fail++;
                $error("FAIL unexpected_out_valid: observed pulse expected none");
            end
            if (exp_q.size() != 0) begin
                chk("digest", hash_out, exp_q.pop_front());
                chk("latency", 160'(cyc - lat_q.pop_front()), 160'(N + 1));
            end
        end
        prev_ov = out_valid;
    end

    // ---------------- driver tasks ----------------
    // Present a block at the negedge and hold it until accepted; returns at
    // the negedge right after the accept edge.
    task automatic send_block(input logic [511:0] data, input logic first, input logic use_iv,
                              input logic [159:0] iv, input logic expect_out,
                              input logic [159:0] exp_digest);
        logic accepted;
        int   acc_edge;
        accepted  = 1'b0;
        acc_edge  = 0;
        blk_valid = 1'b1;
        blk_data  = data;
        blk_first = first;
        iv_use    = use_iv;
        iv_in     = iv;
        for (int k = 0; k < 400 && !accepted; k++) begin
            if (blk_ready === 1'b1 && abort === 1'b0) begin
                acc_edge = cyc + 1;
                accepted = 1'b1;
            end
            @(negedge clk);
        end
        blk_valid = 1'b0;
        blk_first = 1'b0;
        iv_use    = 1'b0;
        iv_in     = '0;
        chk("block_accepted", {159'd0, accepted}, 160'd1);
        if (expect_out && accepted) begin
            exp_q.push_back(exp_digest);
            lat_q.push_back(acc_edge);
            n_expected++;
        end
    endtask

    task automatic wait_drain();
        logic done;
        done = 1'b0;
        for (int k = 0; k < 400 && !done; k++) begin
            if (exp_q.size() == 0) done = 1'b1;
            else @(negedge clk);
        end
        chk("drain_in_time", {159'd0, done}, 160'd1);
        @(negedge clk);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_blk_ready"}, {159'd0, blk_ready}, 160'd1);
        chk({tag, "_busy"}, {159'd0, busy}, 160'd0);
    endtask

    // ---------------- directed sequence ----------------
    logic [159:0] h1;

    initial begin
        rst_n     = 1'b0;
        blk_valid = 1'b0;
        blk_data  = '0;
        blk_first = 1'b0;
        iv_use    = 1'b0;
        iv_in     = '0;
        abort     = 1'b0;
        h1        = ref_sha1(STD_IV, BLK_M1);

        repeat (3) @(negedge clk);
        chk_idle_outputs("reset");
        chk("reset_out_valid", {159'd0, out_valid}, 160'd0);
        chk("reset_hash_out", hash_out, 160'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // "abc": ready low and busy high for the whole run
        send_block(BLK_ABC, 1'b1, 1'b0, '0, 1'b1, DIG_ABC);
        for (int k = 0; k <= N; k++) begin
            chk("run_blk_ready_low", {159'd0, blk_ready}, 160'd0);
            chk("run_busy_high", {159'd0, busy}, 160'd1);
            @(negedge clk);
        end
        chk("done_blk_ready", {159'd0, blk_ready}, 160'd1);
        wait_drain();

        // two-block message, back to back; pulses N+2 cycles apart
        send_block(BLK_M1, 1'b1, 1'b0, '0, 1'b1, h1);
        send_block(BLK_M2, 1'b0, 1'b0, '0, 1'b1, DIG_M2);
        wait_drain();
        chk("back_to_back_gap", 160'(ov_last - ov_prev), 160'(N + 2));

        // midstate chaining from the first-block digest
        send_block(BLK_M2, 1'b1, 1'b1, h1, 1'b1, DIG_M2);
        wait_drain();

        // abort 10 cycles into RUN, then replay the message
        send_block(BLK_M1, 1'b1, 1'b0, '0, 1'b0, '0);
        repeat (10) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk_idle_outputs("after_run_abort");
        chk("after_run_abort_hash", hash_out, DIG_M2);
        send_block(BLK_M1, 1'b1, 1'b0, '0, 1'b1, h1);
        send_block(BLK_M2, 1'b0, 1'b0, '0, 1'b1, DIG_M2);
        wait_drain();

        // abort in FINAL of a continuation block: chain must revert to h1
        send_block(BLK_M1, 1'b1, 1'b0, '0, 1'b1, h1);
        wait_drain();
        send_block(BLK_ABC, 1'b0, 1'b0, '0, 1'b0, '0);
        repeat (N) @(negedge clk);
        chk("final_cycle_busy", {159'd0, busy}, 160'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk_idle_outputs("after_final_abort");
        chk("after_final_abort_hash", hash_out, h1);
        send_block(BLK_M2, 1'b0, 1'b0, '0, 1'b1, DIG_M2);
        wait_drain();

        // abort together with blk_valid in IDLE: nothing accepted
        blk_valid = 1'b1;
        blk_data  = BLK_ABC;
        blk_first = 1'b1;
        abort     = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk_idle_outputs("idle_abort");
        end
        blk_valid = 1'b0;
        blk_first = 1'b0;
        abort     = 1'b0;
        @(negedge clk);
        chk_idle_outputs("idle_abort_after");

        // reset mid-RUN, then "abc" continuing from the reset chain value
        send_block(BLK_ABC, 1'b1, 1'b0, '0, 1'b0, '0);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk_idle_outputs("mid_reset");
            chk("mid_reset_out_valid", {159'd0, out_valid}, 160'd0);
            chk("mid_reset_hash_out", hash_out, 160'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        send_block(BLK_ABC, 1'b0, 1'b0, '0, 1'b1, DIG_ABC);
        wait_drain();

        repeat (5) @(negedge clk);
        chk("pulse_count", 160'(n_pulse), 160'(n_expected));
        chk("scoreboard_empty", 160'(exp_q.size()), 160'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
